// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Optional build macro MDU_FAST_MUL_EN (single-cycle multiply) is consumed in mul_div_unit.sv.
package mdu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ITER_LAST    = 31;
    localparam int unsigned CNT_W        = 5;
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response signals between the execute-stage control and the multiply/divide unit.
interface mul_div_unit_if
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, op_a, op_b, input busy, done, result);
    modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement: y_c = neg ? -a : a.
module mdu_cond_neg
    import mdu_pkg::*;
#(
    parameter int unsigned W = XLEN_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y_c
);
    assign y_c = neg ? (~a + W'(1)) : a;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 32 iterations.
// Build macro MDU_FAST_MUL_EN: multiplies complete combinationally in one cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);
    localparam int unsigned MW = XLEN + 1;
    localparam int unsigned PW = 2 * XLEN;

    mdu_state_t      state, state_nx;
    mdu_op_t         op_in_c, op_q;
    logic            neg_q, neg_r;
    logic [MW-1:0]   opnd;
    logic [XLEN-1:0] hi, lo;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0] result_q;
    logic            busy_q, done_q;

    logic            sa_c, sb_c, is_div_c, div0_c, ovf_c, special_c;
    logic [XLEN-1:0] special_res_c;
    logic [MW-1:0]   mag_a_c, mag_b_c, mul_sum_c, shift_c;
    logic [MW:0]     diff_c;
    logic [XLEN-1:0] hi_nx_c, lo_nx_c, q_fix_c, r_fix_c;
    logic [PW-1:0]   prod_mag_c, p_fix_c;
    logic            prod_neg_c;
    logic            load_c, iter_c, res_ld_c;
    logic [XLEN-1:0] res_nx_c;

    function automatic logic [XLEN-1:0] pick(input mdu_op_t op, input logic [PW-1:0] p,
                                             input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
        case (op)
            OP_MUL:                       pick = p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: pick = p[PW-1:XLEN];
            OP_DIV, OP_DIVU:              pick = q;
            default:                      pick = r;
        endcase
    endfunction

    // Operand decode, sign flags and special-case detection on the incoming request
    always_comb begin
        op_in_c  = mdu_op_t'(bus.funct3);
        sa_c     = bus.op_a[XLEN-1] & (op_in_c inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sb_c     = bus.op_b[XLEN-1] & (op_in_c inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        is_div_c = bus.funct3[2];
        div0_c   = is_div_c && (bus.op_b == '0);
        ovf_c    = (op_in_c inside {OP_DIV, OP_REM}) && (bus.op_a == XLEN'(INT_MIN)) && (bus.op_b == '1);
        special_c = div0_c || ovf_c;
        if (div0_c) special_res_c = bus.funct3[1] ? bus.op_a : XLEN'(DIV0_QUOT);
        else        special_res_c = bus.funct3[1] ? '0 : XLEN'(INT_MIN);
    end

    // Sign-extending into 33 bits keeps |INT_MIN| representable
    mdu_cond_neg #(.W(MW)) u_neg_a (.a({sa_c, bus.op_a}), .neg(sa_c), .y_c(mag_a_c));
    mdu_cond_neg #(.W(MW)) u_neg_b (.a({sb_c, bus.op_b}), .neg(sb_c), .y_c(mag_b_c));

    // One iteration: hi/lo hold product halves for multiply, remainder/quotient for divide
    always_comb begin
        mul_sum_c = {1'b0, hi} + (lo[0] ? opnd : MW'(0));
        shift_c   = {hi, lo[XLEN-1]};
        diff_c    = {1'b0, shift_c} - {1'b0, opnd};
        if (op_q[2]) begin
            hi_nx_c = diff_c[MW] ? XLEN'(shift_c) : XLEN'(diff_c);
            lo_nx_c = {lo[XLEN-2:0], ~diff_c[MW]};
        end else begin
            hi_nx_c = mul_sum_c[MW-1:1];
            lo_nx_c = {mul_sum_c[0], lo[XLEN-1:1]};
        end
    end

`ifdef MDU_FAST_MUL_EN
    assign prod_mag_c = PW'(mag_a_c) * PW'(mag_b_c);
    assign prod_neg_c = sa_c ^ sb_c;
`else
    assign prod_mag_c = {hi_nx_c, lo_nx_c};
    assign prod_neg_c = neg_q;
`endif

    mdu_cond_neg #(.W(PW))   u_neg_p (.a(prod_mag_c), .neg(prod_neg_c), .y_c(p_fix_c));
    mdu_cond_neg #(.W(XLEN)) u_neg_q (.a(lo_nx_c),    .neg(neg_q),      .y_c(q_fix_c));
    mdu_cond_neg #(.W(XLEN)) u_neg_r (.a(hi_nx_c),    .neg(neg_r),      .y_c(r_fix_c));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state; DONE accepts a new request exactly like IDLE
    always_comb begin
        state_nx = state;
        load_c   = 1'b0;
        iter_c   = 1'b0;
        res_ld_c = 1'b0;
        res_nx_c = result_q;
        case (state)
            CALC: begin
                iter_c = 1'b1;
                if (count == CNT_W'(ITER_LAST)) begin
                    state_nx = DONE;
                    res_ld_c = 1'b1;
                    res_nx_c = pick(op_q, p_fix_c, q_fix_c, r_fix_c);
                end
            end
            default: begin
                state_nx = IDLE;
                if (bus.start) begin
                    if (special_c) begin
                        state_nx = DONE;
                        res_ld_c = 1'b1;
                        res_nx_c = special_res_c;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (!is_div_c) begin
                        state_nx = DONE;
                        res_ld_c = 1'b1;
                        res_nx_c = pick(op_in_c, p_fix_c, q_fix_c, r_fix_c);
                    end
`endif
                    else begin
                        state_nx = CALC;
                        load_c   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nx == CALC);
            done_q <= (state_nx == DONE);
            if (res_ld_c) result_q <= res_nx_c;
            if (load_c) begin
                op_q  <= op_in_c;
                neg_q <= sa_c ^ sb_c;
                neg_r <= sa_c;
                opnd  <= is_div_c ? mag_b_c : mag_a_c;
                hi    <= '0;
                lo    <= is_div_c ? XLEN'(mag_a_c) : XLEN'(mag_b_c);
                count <= '0;
            end else if (iter_c) begin
                hi    <= hi_nx_c;
                lo    <= lo_nx_c;
                count <= count + CNT_W'(1);
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: results, latency, busy, hazards and reset.
module tb_mul_div_unit;
    import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    mul_div_unit_if #(.XLEN(32)) bus ();
    mul_div_unit #(.XLEN(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request and count cycles/busy until done (bounded)
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_n);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; busy_n = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        res = bus.result;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.funct3 = 3'b000; bus.op_a = '0; bus.op_b = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.op_a = 32'h1234; bus.op_b = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 00000000", bus.result); end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul;
        vec_t v[7];
        logic [31:0] res; int lat; int bn;
        v[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7x-3"};
        v[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min_min"};
        v[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max_max"};
        v[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1_max"};
        v[4] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MUL_LAT, "mulhu_2p32"};
        v[5] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, MUL_LAT, "mul_2p32_lo"};
        v[6] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, MUL_LAT, "mulh_m1x1"};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, res, lat, bn);
            n_vec++; if (res !== v[i].exp) begin n_err++; $display("FAIL %s result: got %h want %h", v[i].name, res, v[i].exp); end
            n_vec++; if (lat !== v[i].lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
            n_vec++; if (bn !== v[i].lat) begin n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", v[i].name, bn, v[i].lat); end
        end
        @(negedge clk);
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
        n_vec++; if (bus.result !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL result_held: got %h want ffffffff", bus.result); end
    endtask

    task automatic test_div;
        vec_t v[9];
        logic [31:0] res; int lat; int bn;
        v[0] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32, "div_-7_2"};
        v[1] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32, "rem_-7_2"};
        v[2] = '{3'b101, 32'd100,       32'd7,         32'd14,        32, "divu_100_7"};
        v[3] = '{3'b111, 32'd100,       32'd7,         32'd2,         32, "remu_100_7"};
        v[4] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, "div_7_-2"};
        v[5] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32, "rem_7_-2"};
        v[6] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32, "divu_max_1"};
        v[7] = '{3'b100, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 32, "div_min_2"};
        v[8] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32, "divu_min_max"};
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, res, lat, bn);
            n_vec++; if (res !== v[i].exp) begin n_err++; $display("FAIL %s result: got %h want %h", v[i].name, res, v[i].exp); end
            n_vec++; if (lat !== v[i].lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
            n_vec++; if (bn !== v[i].lat) begin n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", v[i].name, bn, v[i].lat); end
        end
    endtask

    task automatic test_special;
        vec_t v[7];
        logic [31:0] res; int lat; int bn;
        v[0] = '{3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 0, "div_by0"};
        v[1] = '{3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 0, "rem_by0"};
        v[2] = '{3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 0, "divu_by0"};
        v[3] = '{3'b111, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 0, "remu_by0"};
        v[4] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf"};
        v[5] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, "rem_ovf"};
        v[6] = '{3'b101, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, "divu_0_by0"};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, res, lat, bn);
            n_vec++; if (res !== v[i].exp) begin n_err++; $display("FAIL %s result: got %h want %h", v[i].name, res, v[i].exp); end
            n_vec++; if (lat !== v[i].lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
            n_vec++; if (bn !== 0) begin n_err++; $display("FAIL %s busy_cycles: got %0d want 0", v[i].name, bn); end
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (lat == 5) begin
                bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'h7; bus.op_b = 32'hFFFF_FFFD;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        n_vec++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL ignored_start result: got %h want 0000000e", bus.result); end
        n_vec++; if (lat !== 32) begin n_err++; $display("FAIL ignored_start latency: got %0d want 32", lat); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res; int lat; int bn;
        run_op(3'b101, 32'd100, 32'd7, res, lat, bn);
        n_vec++; if (res !== 32'd14) begin n_err++; $display("FAIL b2b_first result: got %h want 0000000e", res); end
        bus.start = 1'b1; bus.funct3 = 3'b111; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept busy: got %b want 1", bus.busy); end
        n_vec++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL b2b_hold result: got %h want 0000000e", bus.result); end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        n_vec++; if (bus.result !== 32'd2) begin n_err++; $display("FAIL b2b_second result: got %h want 00000002", bus.result); end
        n_vec++; if (lat !== 32) begin n_err++; $display("FAIL b2b_second latency: got %0d want 32", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res; int lat; int bn; int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.op_a = 32'hFFFF_FFF9; bus.op_b = 32'h2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst done: got %b want 0", bus.done); end
        n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL midrst result: got %h want 00000000", bus.result); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst no_done: got %0d active cycles want 0", seen); end
        run_op(3'b101, 32'd100, 32'd7, res, lat, bn);
        n_vec++; if (res !== 32'd14) begin n_err++; $display("FAIL post_rst result: got %h want 0000000e", res); end
        n_vec++; if (lat !== 32) begin n_err++; $display("FAIL post_rst latency: got %0d want 32", lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes rs1_data/rs2_data.
- Produces a 32-bit result that the control FSM routes to the register file write port (rd_data) when done pulses.
- Multicycle core: control FSM holds the instruction in EX while busy is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled on a clk edge when state != CALC
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1_data
- op_b  in  XLEN  rs2_data
- busy  out  1  high while iterating (state CALC)
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  final value; held until the next accepted start

Behaviour:
- Reset: async assert forces state IDLE, busy=0, done=0, result=0, count=0, internal regs=0.
- Reset mid-CALC aborts the operation; no done is produced.
- States:
  - IDLE: start -> latch funct3, operand magnitudes and sign flags. Go to DONE if special case, else CALC with count=0.
  - CALC: one iteration per cycle, count++. At count==31 apply sign fix, load result, go to DONE.
  - DONE: done=1 for exactly this cycle. start here is accepted exactly as in IDLE (back-to-back ops), else go to IDLE.
- start while in CALC is ignored; operands/funct3 are not re-sampled.
- Latency: start accepted at edge N.
  - Normal op: busy high cycles N+1..N+32; done/result valid at cycle N+33.
  - Special case: done at N+1.
- Multiply: shift-add over 32 cycles on magnitudes; 64-bit product register.
  - Product sign = sa XOR sb, where sa = op_a[31] for MUL/MULH/MULHSU, sb = op_b[31] for MUL/MULH only.
  - MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits of the sign-corrected 64-bit product.
- Divide: restoring, 1 quotient bit per cycle, on magnitudes (signed ops) or raw values (unsigned ops).
  - Quotient negated if signs differ; remainder takes the dividend sign.
- Special cases, no iteration:
  - op_b==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - DIV with op_a=0x80000000, op_b=0xFFFFFFFF -> 0x80000000; REM for the same operands -> 0.
- Magnitude of 0x80000000 is held in 33-bit internal width; no overflow.
- result changes only on transition into DONE.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined:
  - Multiply ops compute the 64-bit signed/unsigned product combinationally from latched operands.
  - Go IDLE -> DONE; done at N+1, busy never asserted for multiplies.
  - Divide is unchanged.
- Undefined: multiplies use the 32-cycle iterative path above.
- Results are identical in both builds.

Decomposition:
- Package mdu_pkg:
  - mdu_op_t enum (funct3 encodings above)
  - mdu_state_t {IDLE, CALC, DONE}
  - XLEN_DEFAULT=32, ITER_LAST=31, DIV0_QUOT=32'hFFFF_FFFF, INT_MIN=32'h8000_0000
- One natural sub-module: mdu_cond_neg, a conditional two's-complement used for operand magnitudes and the final sign fix; instantiated per use.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> result 0xFFFFFFEB, done at N+33, busy high 32 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 with op_a=0x12345678 -> 0xFFFFFFFF at N+1; REM same -> 0x12345678; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- start pulsed during CALC with different operands -> ignored, original result returned; start in DONE cycle -> new op accepted, done for it at +33.
- rst asserted at count==10 -> busy/done/result go to 0 immediately (async); no done follows; next op completes correctly.
